hazard_detection: RTL and testbench
===================================

# hazard_detection

Stall/flush controller for the 5-stage MIPS pipeline; the producer-side counterpart of the EX-stage forwarding logic. Sits beside the ID stage and keeps a shadow record of the destination registers in flight in EX/MEM/WB. When a decoding instruction reads a register that forwarding cannot yet supply, it holds PC and IF/ID and injects a bubble into ID/EX. It also generates the IF/ID flush on a taken branch and counts lost cycles.

## Interface
Parameters:
- CNT_W, 16, width of the saturating stall/flush cycle counters.

Ports:
- clk_i  in  1  pipeline clock; all state updates on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- ID_valid_i  in  1  IF/ID holds a real instruction.
- ID_RS_i  in  5  rs field of the instruction in ID.
- ID_RT_i  in  5  rt field of the instruction in ID.
- ID_use_rs_i  in  1  ID instruction reads rs.
- ID_use_rt_i  in  1  ID instruction reads rt.
- ID_RegWrite_i  in  1  ID instruction writes a register.
- ID_MemRead_i  in  1  ID instruction is a load.
- ID_RD_i  in  5  final destination register (after RegDst mux).
- EX_branch_taken_i  in  1  branch in EX resolved taken this cycle.
- stall_o  out  1  hold PC and IF/ID; force ID/EX control to zero.
- flush_o  out  1  clear IF/ID (wrong-path instruction).
- stall_cnt_o  out  CNT_W  cycles with stall_o=1, saturating.
- flush_cnt_o  out  CNT_W  cycles with flush_o=1, saturating.

## Operation
- Shadow slots EX, MEM, WB, each {valid, rd, regwrite, memread}. A slot is a writer when valid & regwrite & rd!=0.
- Every cycle: WB <= MEM; MEM <= EX; EX <= ID fields if ID_valid_i & !stall_o & !flush_o, else bubble (valid=0).
- Hazard match vs slot S: S is writer & ((ID_use_rs_i & ID_RS_i==S.rd) | (ID_use_rt_i & ID_RT_i==S.rd)).
- With forwarding (see Configuration): stall_o = ID_valid_i & match(EX) & EX.memread & !EX_branch_taken_i. Load-use costs exactly one cycle.
- flush_o = EX_branch_taken_i. Flush wins over stall in the same cycle; the stalled ID instruction is wrong-path and is discarded.
- Register $0 never causes a stall.
- Counters increment by 1 per cycle of the respective output; hold at all-ones.

## Timing
- stall_o, flush_o: combinational from inputs and shadow state; valid same cycle.
- Shadow advances every cycle; never stalled (EX onward always flows).
- Reset: all slots valid=0; stall_o=0, flush_o=0 (given inputs low); stall_cnt_o=0, flush_cnt_o=0. Reset mid-stall clears the stall on the next edge.
- Back-to-back: a load followed by two dependent consumers stalls only the first; after the bubble the load is in MEM and forwarding covers both.
- Simultaneous EX_branch_taken_i and load-use: flush_o=1, stall_o=0, stall counter unchanged.

## Configuration
- HAZARD_FWD_EN defined: forwarding unit present; stall only on load-use vs EX slot, as above.
- HAZARD_FWD_EN undefined: no bypass; stall_o = ID_valid_i & (match(EX)|match(MEM)|match(WB)) & !EX_branch_taken_i. Register file is read-after-write in the same cycle, so WB is included; a dependent ALU op stalls up to 3 cycles.

## Structure
- Shared package pipe_pkg: typedef hz_slot_t {valid, rd[4:0], regwrite, memread}; constant REG_ZERO=5'd0.
- One sub-module: sat_counter (parameter W; inc_i, rst_i, cnt_o), instantiated twice.
- Match logic as a function over hz_slot_t.

## Test plan
- Reset: assert rst_i 2 cycles with ID_valid_i=1 -> stall_o=0, both counters 0, slots empty.
- Load-use (FWD_EN): lw $8 in ID, next cycle add $9,$8,$10 in ID -> stall_o=1 exactly one cycle, stall_cnt_o=1, bubble enters EX.
- ALU dependency (FWD_EN): add $8 then sub $9,$8,$8 -> stall_o stays 0; without macro -> stall_o=1 for 3 cycles, stall_cnt_o=3.
- $0 destination: lw $0 then add using $0 -> no stall in either configuration.
- Flush vs stall: load-use condition and EX_branch_taken_i=1 same cycle -> flush_o=1, stall_o=0, flush_cnt_o=1, EX slot bubble next cycle.
- Saturation: CNT_W=4, hold load-use stall via no-forward config for 20 cycles -> stall_cnt_o=15 and holds.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline types for the hazard controller: shadow-slot record,
// the hard-wired zero register and the slot-versus-decode match helper.
// No ports; imported by hazard_detection.
package pipe_pkg;

   // One in-flight instruction as seen by the hazard unit.
   typedef struct packed {
      logic       valid;
      logic [4:0] rd;
      logic       regwrite;
      logic       memread;
   } hz_slot_t;

   localparam logic [4:0] REG_ZERO = 5'd0;

   // True when slot s will write a register that the decoding instruction reads.
   // Writes to $0 are discarded by the register file, so they never match.
   function automatic logic slot_match(input hz_slot_t s,
                                       input logic use_rs, input logic [4:0] rs,
                                       input logic use_rt, input logic [4:0] rt);
      logic writer;
      writer = s.valid & s.regwrite & (s.rd != REG_ZERO);
      return writer & ((use_rs & (rs == s.rd)) | (use_rt & (rt == s.rd)));
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: increments by one per cycle with inc_i high,
// holds at all-ones, clears on synchronous active-high rst_i.
// Ports: clk_i, rst_i, inc_i in; cnt_o[W-1:0] out (registered).
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         inc_i,
   output logic [W-1:0] cnt_o
);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (inc_i && (cnt_q != {W{1'b1}})) cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/hazard_detection.sv
// Stall/flush controller beside the ID stage of the 5-stage MIPS pipeline.
// Shadows EX/MEM/WB destinations; stall_o/flush_o are combinational, the
// shadow always advances. Counters report lost cycles, saturating.
// Ports: clk_i, rst_i, ID_* decode fields, EX_branch_taken_i in;
//        stall_o, flush_o, stall_cnt_o, flush_cnt_o out.
// Build option: define HAZARD_FWD_EN when the EX forwarding unit is present
// (stall only on load-use against EX); otherwise every in-flight writer
// of a source register stalls decode.
module hazard_detection
   import pipe_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             ID_valid_i,
   input  logic [4:0]       ID_RS_i,
   input  logic [4:0]       ID_RT_i,
   input  logic             ID_use_rs_i,
   input  logic             ID_use_rt_i,
   input  logic             ID_RegWrite_i,
   input  logic             ID_MemRead_i,
   input  logic [4:0]       ID_RD_i,
   input  logic             EX_branch_taken_i,
   output logic             stall_o,
   output logic             flush_o,
   output logic [CNT_W-1:0] stall_cnt_o,
   output logic [CNT_W-1:0] flush_cnt_o
);

   hz_slot_t ex_q, mem_q, wb_q;
   hz_slot_t ex_d;
   logic     match_ex;

   assign match_ex = slot_match(ex_q, ID_use_rs_i, ID_RS_i, ID_use_rt_i, ID_RT_i);

`ifdef HAZARD_FWD_EN
   // Forwarding covers everything except a load still in EX.
   assign stall_o = ID_valid_i & match_ex & ex_q.memread & ~EX_branch_taken_i;
`else
   logic match_mem, match_wb;
   assign match_mem = slot_match(mem_q, ID_use_rs_i, ID_RS_i, ID_use_rt_i, ID_RT_i);
   assign match_wb  = slot_match(wb_q,  ID_use_rs_i, ID_RS_i, ID_use_rt_i, ID_RT_i);
   // WB counts too: the register file write lands at the end of the cycle.
   assign stall_o = ID_valid_i & (match_ex | match_mem | match_wb) & ~EX_branch_taken_i;
`endif

   // A taken branch discards the ID instruction, so it always beats a stall.
   assign flush_o = EX_branch_taken_i;

   always_comb begin
      ex_d = '0;
      if (ID_valid_i && !stall_o && !flush_o) begin
         ex_d.valid    = 1'b1;
         ex_d.rd       = ID_RD_i;
         ex_d.regwrite = ID_RegWrite_i;
         ex_d.memread  = ID_MemRead_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ex_q  <= '0;
         mem_q <= '0;
         wb_q  <= '0;
      end else begin
         ex_q  <= ex_d;
         mem_q <= ex_q;
         wb_q  <= mem_q;
      end
   end

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .inc_i (stall_o),
      .cnt_o (stall_cnt_o)
   );

   sat_counter #(.W(CNT_W)) u_flush_cnt (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .inc_i (flush_o),
      .cnt_o (flush_cnt_o)
   );

endmodule

// File: tb/tb_hazard_detection.sv
// Bench for hazard_detection with CNT_W=4: per-cycle expectations come from
// an independent shadow model pushed into a scoreboard queue and compared at
// the falling edge; directed scenarios also check absolute stall counts.
module tb_hazard_detection;

   localparam int CNT_W = 4;
   localparam int SAT   = 15;
`ifdef HAZARD_FWD_EN
   localparam int LU_STALLS   = 1;
   localparam int ALU_STALLS  = 0;
   localparam int POST_FLUSH  = 0;
   localparam int SC_AT_FLUSH = 2;
`else
   localparam int LU_STALLS   = 3;
   localparam int ALU_STALLS  = 3;
   localparam int POST_FLUSH  = 2;
   localparam int SC_AT_FLUSH = 9;
`endif

   logic             clk = 1'b0;
   logic             rst_i, ID_valid_i, ID_use_rs_i, ID_use_rt_i;
   logic             ID_RegWrite_i, ID_MemRead_i, EX_branch_taken_i;
   logic [4:0]       ID_RS_i, ID_RT_i, ID_RD_i;
   logic             stall_o, flush_o;
   logic [CNT_W-1:0] stall_cnt_o, flush_cnt_o;

   always #5 clk = ~clk;

   hazard_detection #(.CNT_W(CNT_W)) dut (
      .clk_i             (clk),
      .rst_i             (rst_i),
      .ID_valid_i        (ID_valid_i),
      .ID_RS_i           (ID_RS_i),
      .ID_RT_i           (ID_RT_i),
      .ID_use_rs_i       (ID_use_rs_i),
      .ID_use_rt_i       (ID_use_rt_i),
      .ID_RegWrite_i     (ID_RegWrite_i),
      .ID_MemRead_i      (ID_MemRead_i),
      .ID_RD_i           (ID_RD_i),
      .EX_branch_taken_i (EX_branch_taken_i),
      .stall_o           (stall_o),
      .flush_o           (flush_o),
      .stall_cnt_o       (stall_cnt_o),
      .flush_cnt_o       (flush_cnt_o)
   );

   typedef struct {
      logic st;
      logic fl;
      int   sc;
      int   fc;
   } exp_t;

   exp_t exp_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   // Model state, index 0=EX, 1=MEM, 2=WB.
   logic       m_v[3], m_rw[3], m_mr[3];
   logic [4:0] m_rd[3];
   int         m_sc, m_fc;

   task automatic check(input string tag, input int got, input int exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < 3; i++) begin
         m_v[i] = 1'b0; m_rw[i] = 1'b0; m_mr[i] = 1'b0; m_rd[i] = 5'd0;
      end
      m_sc = 0;
      m_fc = 0;
   endtask

   // One pipeline cycle: drive, predict, compare at negedge, advance model.
   task automatic cyc(input logic rst, input logic v,
                      input logic [4:0] rs, input logic [4:0] rt,
                      input logic urs, input logic urt, input logic rw,
                      input logic mr, input logic [4:0] rd, input logic br,
                      output logic st);
      logic hit[3];
      logic any;
      exp_t e, got_e;
      rst_i = rst; ID_valid_i = v; ID_RS_i = rs; ID_RT_i = rt;
      ID_use_rs_i = urs; ID_use_rt_i = urt; ID_RegWrite_i = rw;
      ID_MemRead_i = mr; ID_RD_i = rd; EX_branch_taken_i = br;
      for (int i = 0; i < 3; i++)
         hit[i] = m_v[i] && m_rw[i] && (m_rd[i] != 5'd0) &&
                  ((urs && rs == m_rd[i]) || (urt && rt == m_rd[i]));
`ifdef HAZARD_FWD_EN
      any = hit[0] && m_mr[0];
`else
      any = hit[0] || hit[1] || hit[2];
`endif
      e.st = v && any && !br;
      e.fl = br;
      e.sc = m_sc;
      e.fc = m_fc;
      exp_q.push_back(e);
      @(negedge clk);
      if (exp_q.size() == 0) begin
         check("scoreboard_empty", 0, 1);
      end else begin
         got_e = exp_q.pop_front();
         check("stall_o",     int'(stall_o),     int'(got_e.st));
         check("flush_o",     int'(flush_o),     int'(got_e.fl));
         check("stall_cnt_o", int'(stall_cnt_o), got_e.sc);
         check("flush_cnt_o", int'(flush_cnt_o), got_e.fc);
      end
      st = e.st;
      @(posedge clk);
      if (rst) begin
         model_clear();
      end else begin
         if (e.st && m_sc < SAT) m_sc++;
         if (e.fl && m_fc < SAT) m_fc++;
         for (int i = 2; i > 0; i--) begin
            m_v[i] = m_v[i-1]; m_rw[i] = m_rw[i-1];
            m_mr[i] = m_mr[i-1]; m_rd[i] = m_rd[i-1];
         end
         m_v[0]  = v && !e.st && !e.fl;
         m_rw[0] = m_v[0] ? rw : 1'b0;
         m_mr[0] = m_v[0] ? mr : 1'b0;
         m_rd[0] = m_v[0] ? rd : 5'd0;
      end
      #1;
   endtask

   // Present an instruction until decode accepts it; returns stall cycles.
   task automatic issue(input string name, input logic [4:0] rs, input logic [4:0] rt,
                        input logic urs, input logic urt, input logic rw,
                        input logic mr, input logic [4:0] rd, input logic br,
                        output int stalls);
      logic st;
      logic done;
      stalls = 0;
      done   = 1'b0;
      for (int k = 0; k < 8 && !done; k++) begin
         cyc(1'b0, 1'b1, rs, rt, urs, urt, rw, mr, rd, br, st);
         if (st) stalls++;
         else    done = 1'b1;
      end
      if (!done) check({name, "_timeout"}, 0, 1);
   endtask

   task automatic nops(input int n);
      logic st;
      for (int k = 0; k < n; k++)
         cyc(1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, st);
   endtask

   initial begin
      int   s;
      logic st;
      rst_i = 1'b1; ID_valid_i = 1'b1; ID_RS_i = 5'd8; ID_RT_i = 5'd8;
      ID_use_rs_i = 1'b1; ID_use_rt_i = 1'b1; ID_RegWrite_i = 1'b1;
      ID_MemRead_i = 1'b0; ID_RD_i = 5'd8; EX_branch_taken_i = 1'b0;
      model_clear();
      // First reset cycle: DUT state is unknown until this edge.
      @(posedge clk); #1;
      cyc(1'b1, 1'b1, 5'd8, 5'd8, 1'b1, 1'b1, 1'b1, 1'b0, 5'd8, 1'b0, st);
      check("reset_stall_cnt", int'(stall_cnt_o), 0);
      check("reset_flush_cnt", int'(flush_cnt_o), 0);

      // Load-use: lw $8 ; add $9,$8,$10
      issue("lw8",  5'd1, 5'd0,  1'b1, 1'b0, 1'b1, 1'b1, 5'd8, 1'b0, s);
      check("lw8_stalls", s, 0);
      issue("add9", 5'd8, 5'd10, 1'b1, 1'b1, 1'b1, 1'b0, 5'd9, 1'b0, s);
      check("loaduse_stalls", s, LU_STALLS);
      nops(3);

      // Load followed by two consumers: only the first waits.
      issue("lw11", 5'd1,  5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd11, 1'b0, s);
      issue("use1", 5'd11, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0, 5'd3,  1'b0, s);
      check("b2b_first_stalls", s, LU_STALLS);
      issue("use2", 5'd2, 5'd11, 1'b1, 1'b1, 1'b1, 1'b0, 5'd4,  1'b0, s);
      check("b2b_second_stalls", s, 0);
      nops(3);

      // ALU dependency: add $8 ; sub $9,$8,$8
      issue("add8", 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0, 5'd8, 1'b0, s);
      issue("sub9", 5'd8, 5'd8, 1'b1, 1'b1, 1'b1, 1'b0, 5'd9, 1'b0, s);
      check("alu_dep_stalls", s, ALU_STALLS);
      nops(3);

      // $0 destination never stalls.
      issue("lw0",  5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd0,  1'b0, s);
      issue("use0", 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0, 5'd15, 1'b0, s);
      check("zero_reg_stalls", s, 0);
      nops(3);

      // Flush beats stall; the discarded instruction leaves a bubble in EX.
      issue("lw12",  5'd1,  5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd12, 1'b0, s);
      issue("brcon", 5'd12, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd5,  1'b1, s);
      check("flush_vs_stall_stalls", s, 0);
      check("flush_cnt_after_flush", int'(flush_cnt_o), 1);
      check("stall_cnt_unchanged",   int'(stall_cnt_o), SC_AT_FLUSH);
      issue("after", 5'd12, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd6, 1'b0, s);
      check("post_flush_stalls", s, POST_FLUSH);
      nops(3);

      // Reset in the middle of a load-use stall.
      issue("lw13", 5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd13, 1'b0, s);
      cyc(1'b0, 1'b1, 5'd13, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd7, 1'b0, st);
      check("midstall_pre", int'(st), 1);
      cyc(1'b1, 1'b1, 5'd13, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd7, 1'b0, st);
      check("midstall_rst_stall_cnt", int'(stall_cnt_o), 0);
      check("midstall_rst_stall_o",   int'(stall_o),     0);
      cyc(1'b0, 1'b1, 5'd13, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd7, 1'b0, st);
      nops(3);

      // Saturation of both counters.
      for (int r = 0; r < 18; r++) begin
         issue("lw14",  5'd1,  5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd14, 1'b0, s);
         issue("use14", 5'd14, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd16, 1'b0, s);
         nops(3);
      end
      check("stall_cnt_saturated", int'(stall_cnt_o), SAT);
      for (int r = 0; r < 20; r++)
         cyc(1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, st);
      check("flush_cnt_saturated", int'(flush_cnt_o), SAT);
      check("stall_cnt_holds",     int'(stall_cnt_o), SAT);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   // Global time bound so the run always ends.
   initial begin
      #200000;
      $display("FAIL global_timeout got=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
